// File: rtl/collision_pkg.sv
// Shared types and helpers for the collision scanner.
// The box struct is sized by BOX_COORD_W (default 12). Scanner instances use
// COORD_W <= BOX_COORD_W; narrower fields are zero-extended into the struct.
package collision_pkg;

  localparam int BOX_COORD_W = 12;

  typedef struct packed {
    logic [BOX_COORD_W-1:0] width;
    logic [BOX_COORD_W-1:0] height;
    logic [BOX_COORD_W-1:0] screen_x;
    logic [BOX_COORD_W-1:0] screen_y;
  } collision_box;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } scan_state_e;

  // One-hot hit_side encodings, ordered {top, bottom, left, right}
  localparam logic [3:0] SIDE_TOP    = 4'b1000;
  localparam logic [3:0] SIDE_BOTTOM = 4'b0100;
  localparam logic [3:0] SIDE_LEFT   = 4'b0010;
  localparam logic [3:0] SIDE_RIGHT  = 4'b0001;

  // Axis-aligned overlap with tolerance. Sums carry two guard bits so that
  // coordinates near the top of the range never wrap into a false result.
  function automatic logic box_overlap(input collision_box a,
                                       input collision_box b,
                                       input logic [BOX_COORD_W-1:0] margin);
    logic [BOX_COORD_W+1:0] ax_end;
    logic [BOX_COORD_W+1:0] bx_end;
    logic [BOX_COORD_W+1:0] ay_end;
    logic [BOX_COORD_W+1:0] by_end;
    ax_end = {2'b00, a.screen_x} + {2'b00, a.width}  + {2'b00, margin};
    bx_end = {2'b00, b.screen_x} + {2'b00, b.width}  + {2'b00, margin};
    ay_end = {2'b00, a.screen_y} + {2'b00, a.height} + {2'b00, margin};
    by_end = {2'b00, b.screen_y} + {2'b00, b.height} + {2'b00, margin};
    return (ax_end > {2'b00, b.screen_x}) &&
           (bx_end > {2'b00, a.screen_x}) &&
           (ay_end > {2'b00, b.screen_y}) &&
           (by_end > {2'b00, a.screen_y});
  endfunction

endpackage

// File: rtl/collision_side_resolver.sv
// Combinational penetration depth / minimum-select for the hit side.
// Only instantiated when COLLISION_SIDE_EN is defined.
module collision_side_resolver
  import collision_pkg::*;
(
  input  collision_box probe,
  input  collision_box target,
  output logic [3:0]   side
);

  localparam int PW = BOX_COORD_W + 2;

  logic [PW-1:0] pen_top_s;
  logic [PW-1:0] pen_bottom_s;
  logic [PW-1:0] pen_left_s;
  logic [PW-1:0] pen_right_s;

  assign pen_top_s    = {2'b00, probe.screen_y}  + {2'b00, probe.height}  - {2'b00, target.screen_y};
  assign pen_bottom_s = {2'b00, target.screen_y} + {2'b00, target.height} - {2'b00, probe.screen_y};
  assign pen_left_s   = {2'b00, probe.screen_x}  + {2'b00, probe.width}   - {2'b00, target.screen_x};
  assign pen_right_s  = {2'b00, target.screen_x} + {2'b00, target.width}  - {2'b00, probe.screen_x};

  // Pick the shallowest penetration; ties go top > bottom > left > right
  always_comb begin
    side = 4'b0000;
    if ((pen_top_s <= pen_bottom_s) && (pen_top_s <= pen_left_s) && (pen_top_s <= pen_right_s)) begin
      side = SIDE_TOP;
    end else if ((pen_bottom_s <= pen_left_s) && (pen_bottom_s <= pen_right_s)) begin
      side = SIDE_BOTTOM;
    end else if (pen_left_s <= pen_right_s) begin
      side = SIDE_LEFT;
    end else begin
      side = SIDE_RIGHT;
    end
  end

endmodule

// File: rtl/collision_scanner.sv
// Sequential probe-vs-targets collision scanner, one target per clock.
// Optional macro COLLISION_SIDE_EN adds the hit_side output (side of the
// first hit, by minimum penetration).
module collision_scanner
  import collision_pkg::*;
#(
  parameter int          N_BOXES = 4,
  parameter int          COORD_W = 12,
  parameter int unsigned MARGIN  = 0,
  parameter int          IDX_W   = (N_BOXES > 1) ? $clog2(N_BOXES) : 1
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           start,
  input  logic [4*COORD_W-1:0]           probe_box,
  input  logic [N_BOXES*4*COORD_W-1:0]   target_boxes,
  input  logic [N_BOXES-1:0]             target_en,
  output logic                           busy,
  output logic                           done,
  output logic [N_BOXES-1:0]             hit_map,
  output logic                           any_hit,
  output logic [IDX_W-1:0]               first_hit_idx
`ifdef COLLISION_SIDE_EN
  ,
  output logic [3:0]                     hit_side
`endif
);

  localparam int                     BOX_BITS = 4 * COORD_W;
  localparam logic [IDX_W-1:0]       LAST_IDX = IDX_W'(N_BOXES - 1);
  localparam logic [BOX_COORD_W-1:0] MARGIN_V = BOX_COORD_W'(MARGIN);

  scan_state_e state_r;
  scan_state_e state_next_s;

  logic [BOX_BITS-1:0]         probe_snap_r;
  logic [N_BOXES*BOX_BITS-1:0] target_snap_r;
  logic [N_BOXES-1:0]          en_snap_r;
  logic [IDX_W-1:0]            idx_r;

  logic [N_BOXES-1:0] hit_acc_r;
  logic [IDX_W-1:0]   first_acc_r;
  logic               found_r;

  collision_box       probe_s;
  collision_box       target_s;
  logic               target_hit_s;
  logic [N_BOXES-1:0] hit_final_s;
  logic [IDX_W-1:0]   first_final_s;
  logic               found_final_s;

  // Unpack a {width, height, screen_x, screen_y} word into the shared struct
  function automatic collision_box to_box(input logic [BOX_BITS-1:0] raw);
    collision_box b;
    b.width    = BOX_COORD_W'(raw[4*COORD_W-1 -: COORD_W]);
    b.height   = BOX_COORD_W'(raw[3*COORD_W-1 -: COORD_W]);
    b.screen_x = BOX_COORD_W'(raw[2*COORD_W-1 -: COORD_W]);
    b.screen_y = BOX_COORD_W'(raw[COORD_W-1 -: COORD_W]);
    return b;
  endfunction

  assign probe_s      = to_box(probe_snap_r);
  assign target_s     = to_box(target_snap_r[idx_r*BOX_BITS +: BOX_BITS]);
  assign target_hit_s = en_snap_r[idx_r] & box_overlap(probe_s, target_s, MARGIN_V);

`ifdef COLLISION_SIDE_EN
  logic [3:0] side_s;
  logic [3:0] side_acc_r;
  logic [3:0] side_final_s;

  collision_side_resolver u_side (
    .probe  (probe_s),
    .target (target_s),
    .side   (side_s)
  );
`endif

  // Fold the current target's result into the accumulators
  always_comb begin
    hit_final_s   = hit_acc_r;
    first_final_s = first_acc_r;
    found_final_s = found_r;
`ifdef COLLISION_SIDE_EN
    side_final_s  = side_acc_r;
`endif
    if (target_hit_s) begin
      hit_final_s[idx_r] = 1'b1;
      if (!found_r) begin
        first_final_s = idx_r;
        found_final_s = 1'b1;
`ifdef COLLISION_SIDE_EN
        side_final_s  = side_s;
`endif
      end else begin
        found_final_s = 1'b1;
      end
    end else begin
      found_final_s = found_r;
    end
  end

  // Next-state logic: start only honoured in IDLE, scan ends on the last index
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start) begin
          state_next_s = SCAN;
        end else begin
          state_next_s = IDLE;
        end
      end
      SCAN: begin
        if (idx_r == LAST_IDX) begin
          state_next_s = DONE;
        end else begin
          state_next_s = SCAN;
        end
      end
      DONE:    state_next_s = IDLE;
      default: state_next_s = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Snapshot, accumulation and output registers; results land together with
  // the move into DONE so done is high during the DONE cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      probe_snap_r  <= '0;
      target_snap_r <= '0;
      en_snap_r     <= '0;
      idx_r         <= '0;
      hit_acc_r     <= '0;
      first_acc_r   <= '0;
      found_r       <= 1'b0;
      busy          <= 1'b0;
      done          <= 1'b0;
      hit_map       <= '0;
      any_hit       <= 1'b0;
      first_hit_idx <= '0;
`ifdef COLLISION_SIDE_EN
      side_acc_r    <= 4'b0000;
      hit_side      <= 4'b0000;
`endif
    end else begin
      busy <= (state_next_s == SCAN);
      done <= 1'b0;
      case (state_r)
        IDLE: begin
          if (start) begin
            probe_snap_r  <= probe_box;
            target_snap_r <= target_boxes;
            en_snap_r     <= target_en;
            idx_r         <= '0;
            hit_acc_r     <= '0;
            first_acc_r   <= '0;
            found_r       <= 1'b0;
`ifdef COLLISION_SIDE_EN
            side_acc_r    <= 4'b0000;
`endif
          end
        end
        SCAN: begin
          hit_acc_r   <= hit_final_s;
          first_acc_r <= first_final_s;
          found_r     <= found_final_s;
          idx_r       <= idx_r + IDX_W'(1);
`ifdef COLLISION_SIDE_EN
          side_acc_r  <= side_final_s;
`endif
          if (idx_r == LAST_IDX) begin
            hit_map       <= hit_final_s;
            any_hit       <= |hit_final_s;
            first_hit_idx <= first_final_s;
            done          <= 1'b1;
`ifdef COLLISION_SIDE_EN
            hit_side      <= side_final_s;
`endif
          end
        end
        DONE: begin
          idx_r <= '0;
        end
        default: begin
          idx_r <= '0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_collision_scanner.sv
// Directed self-checking bench for collision_scanner (N=4, MARGIN 0 and 1).
module tb_collision_scanner;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic [47:0]  probe;
  logic [191:0] targets;
  logic [3:0]   en;

  logic       busy0, done0, any0;
  logic [3:0] map0;
  logic [1:0] idx0;
  logic       busy1, done1, any1;
  logic [3:0] map1;
  logic [1:0] idx1;
`ifdef COLLISION_SIDE_EN
  logic [3:0] side0, side1;
`endif

  int checks = 0;
  int errors = 0;

  logic [47:0] far_box;
  logic [47:0] ov_box;

  always #5 clk = ~clk;

  collision_scanner #(.N_BOXES(4), .COORD_W(12), .MARGIN(0)) dut0 (
    .clk(clk), .rst(rst), .start(start), .probe_box(probe),
    .target_boxes(targets), .target_en(en), .busy(busy0), .done(done0),
    .hit_map(map0), .any_hit(any0), .first_hit_idx(idx0)
`ifdef COLLISION_SIDE_EN
    , .hit_side(side0)
`endif
  );

  collision_scanner #(.N_BOXES(4), .COORD_W(12), .MARGIN(1)) dut1 (
    .clk(clk), .rst(rst), .start(start), .probe_box(probe),
    .target_boxes(targets), .target_en(en), .busy(busy1), .done(done1),
    .hit_map(map1), .any_hit(any1), .first_hit_idx(idx1)
`ifdef COLLISION_SIDE_EN
    , .hit_side(side1)
`endif
  );

  function automatic logic [47:0] bx(input int w, input int h, input int x, input int y);
    return {12'(w), 12'(h), 12'(x), 12'(y)};
  endfunction

  task automatic set_targets(input logic [47:0] t0, input logic [47:0] t1,
                             input logic [47:0] t2, input logic [47:0] t3);
    targets = {t3, t2, t1, t0};
  endtask

  // Pulse start for one cycle and wait (bounded) for done; cyc = cycle of done
  task automatic run_scan(output int cyc);
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    cyc = 1;
    while (done0 !== 1'b1 && cyc < 20) begin
      @(negedge clk);
      cyc++;
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; probe = '0; targets = '0; en = '0;
    @(negedge clk);
    @(negedge clk);
    checks++; if ({busy0, done0, map0, any0, idx0} !== 9'd0) begin errors++; $display("FAIL reset_dut0 got %b want 0", {busy0, done0, map0, any0, idx0}); end
    checks++; if ({busy1, done1, map1, any1, idx1} !== 9'd0) begin errors++; $display("FAIL reset_dut1 got %b want 0", {busy1, done1, map1, any1, idx1}); end
    rst = 1'b0;
  endtask

  task automatic test_basic_hit();
    int cyc;
    probe = bx(16, 16, 100, 100);
    set_targets(ov_box, far_box, far_box, far_box);
    en = 4'b1111;
    run_scan(cyc);
    checks++; if (cyc !== 5) begin errors++; $display("FAIL basic_latency got %0d want 5", cyc); end
    checks++; if (map0 !== 4'b0001) begin errors++; $display("FAIL basic_map got %b want 0001", map0); end
    checks++; if (any0 !== 1'b1) begin errors++; $display("FAIL basic_any got %b want 1", any0); end
    checks++; if (idx0 !== 2'd0) begin errors++; $display("FAIL basic_idx got %0d want 0", idx0); end
    checks++; if (done1 !== 1'b1 || map1 !== 4'b0001) begin errors++; $display("FAIL basic_m1 got done=%b map=%b want 1 0001", done1, map1); end
    @(negedge clk);
    checks++; if (done0 !== 1'b0) begin errors++; $display("FAIL basic_done_pulse got %b want 0", done0); end
    checks++; if (map0 !== 4'b0001) begin errors++; $display("FAIL basic_hold got %b want 0001", map0); end
  endtask

  task automatic test_edge_touch();
    int cyc;
    probe = bx(16, 16, 100, 100);
    set_targets(far_box, far_box, bx(10, 10, 116, 100), far_box);
    en = 4'b1111;
    run_scan(cyc);
    checks++; if (map0 !== 4'b0000 || any0 !== 1'b0) begin errors++; $display("FAIL touch_m0 got map=%b any=%b want 0000 0", map0, any0); end
    checks++; if (idx0 !== 2'd0) begin errors++; $display("FAIL touch_m0_idx got %0d want 0", idx0); end
    checks++; if (map1 !== 4'b0100 || any1 !== 1'b1) begin errors++; $display("FAIL touch_m1 got map=%b any=%b want 0100 1", map1, any1); end
    checks++; if (idx1 !== 2'd2) begin errors++; $display("FAIL touch_m1_idx got %0d want 2", idx1); end
  endtask

  task automatic test_enable();
    int cyc;
    probe = bx(16, 16, 100, 100);
    set_targets(ov_box, ov_box, far_box, ov_box);
    en = 4'b1110;
    run_scan(cyc);
    checks++; if (map0 !== 4'b1010 || idx0 !== 2'd1) begin errors++; $display("FAIL enable_a got map=%b idx=%0d want 1010 1", map0, idx0); end
    en = 4'b1100;
    run_scan(cyc);
    checks++; if (map0 !== 4'b1000 || idx0 !== 2'd3) begin errors++; $display("FAIL enable_b got map=%b idx=%0d want 1000 3", map0, idx0); end
  endtask

  task automatic test_overflow();
    int cyc;
    probe = bx(100, 100, 4000, 4000);
    set_targets(bx(200, 200, 50, 50), bx(10, 10, 4050, 4050), far_box, far_box);
    en = 4'b1111;
    run_scan(cyc);
    checks++; if (map0 !== 4'b0010 || idx0 !== 2'd1 || any0 !== 1'b1) begin errors++; $display("FAIL overflow_m0 got map=%b idx=%0d any=%b want 0010 1 1", map0, idx0, any0); end
    checks++; if (map1 !== 4'b0010) begin errors++; $display("FAIL overflow_m1 got %b want 0010", map1); end
  endtask

  task automatic test_back_to_back();
    int n_done;
    int first_done;
    logic [3:0] map_at_done;
    n_done = 0; first_done = 0; map_at_done = 4'b0000;
    probe = bx(16, 16, 100, 100);
    set_targets(ov_box, far_box, far_box, far_box);
    en = 4'b1111;
    @(negedge clk);
    start = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (done0 === 1'b1) begin
        n_done++;
        if (first_done == 0) begin first_done = c; map_at_done = map0; end
      end
      if (c == 4) begin
        checks++; if (busy0 !== 1'b1) begin errors++; $display("FAIL b2b_busy4 got %b want 1", busy0); end
      end
      if (c == 5) begin
        checks++; if (busy0 !== 1'b0) begin errors++; $display("FAIL b2b_busy5 got %b want 0", busy0); end
      end
      if (c == 2) begin
        probe = bx(10, 10, 3000, 3000);
        set_targets(ov_box, ov_box, ov_box, ov_box);
        en = 4'b0000;
        start = 1'b1;
      end
    end
    checks++; if (n_done !== 1) begin errors++; $display("FAIL b2b_done_count got %0d want 1", n_done); end
    checks++; if (first_done !== 5) begin errors++; $display("FAIL b2b_done_cycle got %0d want 5", first_done); end
    checks++; if (map_at_done !== 4'b0001) begin errors++; $display("FAIL b2b_snapshot got %b want 0001", map_at_done); end
    checks++; if (map0 !== 4'b0001 || any0 !== 1'b1) begin errors++; $display("FAIL b2b_hold got map=%b any=%b want 0001 1", map0, any0); end
  endtask

  task automatic test_reset_abort();
    int n_done;
    int cyc;
    n_done = 0;
    probe = bx(16, 16, 100, 100);
    set_targets(far_box, ov_box, far_box, far_box);
    en = 4'b1111;
    @(negedge clk);
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    #1;
    checks++; if ({busy0, done0, map0, any0, idx0} !== 9'd0) begin errors++; $display("FAIL abort_outputs got %b want 0", {busy0, done0, map0, any0, idx0}); end
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 10; c++) begin
      @(negedge clk);
      if (done0 === 1'b1) n_done++;
    end
    checks++; if (n_done !== 0) begin errors++; $display("FAIL abort_no_done got %0d want 0", n_done); end
    run_scan(cyc);
    checks++; if (cyc !== 5 || map0 !== 4'b0010 || idx0 !== 2'd1) begin errors++; $display("FAIL abort_recover got cyc=%0d map=%b idx=%0d want 5 0010 1", cyc, map0, idx0); end
  endtask

`ifdef COLLISION_SIDE_EN
  task automatic test_side();
    int cyc;
    probe = bx(16, 16, 100, 90);
    set_targets(bx(40, 40, 90, 104), far_box, far_box, far_box);
    en = 4'b1111;
    run_scan(cyc);
    checks++; if (side0 !== 4'b1000 || map0 !== 4'b0001) begin errors++; $display("FAIL side_top got side=%b map=%b want 1000 0001", side0, map0); end
    probe = bx(10, 10, 3000, 3000);
    run_scan(cyc);
    checks++; if (side0 !== 4'b0000 || any0 !== 1'b0) begin errors++; $display("FAIL side_none got side=%b any=%b want 0000 0", side0, any0); end
  endtask
`endif

  initial begin
    far_box = bx(10, 10, 2000, 2000);
    ov_box  = bx(20, 20, 110, 110);
    test_reset();
    test_basic_hit();
    test_edge_touch();
    test_enable();
    test_overflow();
    test_back_to_back();
    test_reset_abort();
`ifdef COLLISION_SIDE_EN
    test_side();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
